random_gen: RTL and testbench

Parametrised pseudo-random source that replaces the fixed 256-bit free-running generator with a seedable Galois LFSR. It provides configurable state and output width, multiple LFSR steps per clock, zero-seed lockout protection and a post-seed warm-up phase. Output is delivered over a valid/ready handshake. It sits between game/graphics logic and any consumer needing a stream of random words, and holds its sequence while the consumer stalls.

---
 rtl/random_gen_pkg.sv | 19 +
 rtl/random_gen_if.sv | 23 ++
 rtl/random_gen_lfsr_step.sv | 13 +
 rtl/random_gen.sv | 106 ++++++++++
 tb/tb_random_gen.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/random_gen_pkg.sv
// random_gen shared types and default LFSR constants.
// Polynomials are Galois right-shift masks, maximal for their width.
package random_pkg;

  typedef enum logic {
    ST_WARMUP,
    ST_RUN
  } fsm_e;

  localparam logic [7:0]  POLY_8  = 8'hB8;
  localparam logic [7:0]  SEED_8  = 8'h01;
  localparam logic [15:0] POLY_16 = 16'hB400;
  localparam logic [15:0] SEED_16 = 16'hACE1;
  localparam logic [31:0] POLY_32 = 32'h8020_0003;
  localparam logic [31:0] SEED_32 = 32'h1234_5678;
  localparam logic [63:0] POLY_64 = 64'hD800_0000_0000_0000;
  localparam logic [63:0] SEED_64 = 64'h5F48_E307_FB7F_9FC8;

endpackage

// File: rtl/random_gen_if.sv
// Output handshake of random_gen.
// master drives the word, slave accepts it.
interface random_gen_if #(
  parameter int OUT_WIDTH = 32
);

  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] out_data;

  modport master (
    output out_valid,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    output out_ready
  );

endinterface

// File: rtl/random_gen_lfsr_step.sv
// One combinational Galois right-shift LFSR step.
// Feedback mask is applied when the shifted-out bit is 1.
module lfsr_step #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY  = '0
) (
  input  logic [WIDTH-1:0] s_i,
  output logic [WIDTH-1:0] s_o
);

  assign s_o = (s_i >> 1) ^ (s_i[0] ? POLY : '0);

endmodule

// File: rtl/random_gen.sv
// Seedable Galois LFSR random word source with warm-up.
// State only advances in warm-up or when a word is loaded.
module random_gen
  import random_pkg::*;
#(
  parameter int               WIDTH        = 64,
  parameter int               OUT_WIDTH    = 32,
  parameter logic [WIDTH-1:0] POLY         = POLY_64,
  parameter int               STEPS        = 32,
  parameter int               WARMUP       = 16,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = SEED_64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic             enable,
  output logic             busy,
  output logic [31:0]      count,
  random_gen_if.master     out_if
);

  localparam int WW = $clog2(WARMUP + 1);

  fsm_e                 fsm_q, fsm_d;
  logic [WW-1:0]        warm_q, warm_d;
  logic [WIDTH-1:0]     state_q, state_d;
  logic                 valid_q, valid_d;
  logic [OUT_WIDTH-1:0] data_q, data_d;
  logic [31:0]          count_q, count_d;
  logic [WIDTH-1:0]     chain [STEPS+1];

  assign chain[0] = state_q;

  for (genvar g = 0; g < STEPS; g++) begin : g_step
    lfsr_step #(
      .WIDTH (WIDTH),
      .POLY  (POLY)
    ) u_step (
      .s_i (chain[g]),
      .s_o (chain[g+1])
    );
  end

  always_comb begin
    fsm_d   = fsm_q;
    warm_d  = warm_q;
    state_d = state_q;
    valid_d = valid_q;
    data_d  = data_q;
    count_d = count_q;
    if (seed_load) begin
      state_d = (seed == '0) ? DEFAULT_SEED : seed;
      fsm_d   = ST_WARMUP;
      warm_d  = '0;
      valid_d = 1'b0;
      count_d = '0;
    end else begin
      unique case (fsm_q)
        ST_WARMUP: begin
          state_d = chain[STEPS];
          warm_d  = warm_q + WW'(1);
          if (warm_q == WW'(WARMUP - 1)) begin
            fsm_d  = ST_RUN;
            warm_d = '0;
          end
        end
        ST_RUN: begin
          if (enable && (!valid_q || out_if.out_ready)) begin
            data_d  = state_q[OUT_WIDTH-1:0];
            state_d = chain[STEPS];
            valid_d = 1'b1;
            count_d = count_q + 32'd1;
          end else if (valid_q && out_if.out_ready) begin
            valid_d = 1'b0;
          end
        end
        default: fsm_d = ST_WARMUP;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= ST_WARMUP;
      warm_q  <= '0;
      state_q <= DEFAULT_SEED;
      valid_q <= 1'b0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      warm_q  <= warm_d;
      state_q <= state_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  assign busy             = (fsm_q == ST_WARMUP);
  assign count            = count_q;
  assign out_if.out_valid = valid_q;
  assign out_if.out_data  = data_q;

endmodule

// File: tb/tb_random_gen.sv
// Scoreboard bench for random_gen in the 8-bit configuration.
// Expected words come from an independent LFSR model.
module tb_random_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        seed_load;
  logic [7:0]  seed;
  logic        enable;
  logic        busy;
  logic [31:0] count;

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  sb [$];
  logic [7:0]  hist [$];
  logic [7:0]  m;
  logic [7:0]  e;

  random_gen_if #(.OUT_WIDTH(8)) bus ();

  random_gen #(
    .WIDTH        (8),
    .OUT_WIDTH    (8),
    .POLY         (8'hB8),
    .STEPS        (1),
    .WARMUP       (1),
    .DEFAULT_SEED (8'h01)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .seed_load (seed_load),
    .seed      (seed),
    .enable    (enable),
    .busy      (busy),
    .count     (count),
    .out_if    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] lfsr8(input logic [7:0] s);
    return s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_seed(input logic [7:0] s);
    m = lfsr8((s == 8'h00) ? 8'h01 : s);
  endtask

  task automatic push_model(input int n);
    for (int i = 0; i < n; i++) begin
      sb.push_back(m);
      m = lfsr8(m);
    end
  endtask

  always @(negedge clk) begin
    if (bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 64'(sb.size()), 64'd1);
      end else begin
        e = sb.pop_front();
        chk("sb_word", 64'(bus.out_data), 64'(e));
      end
      hist.push_back(bus.out_data);
    end
  end

  initial begin
    int bad;
    logic seen [256];
    rst = 1'b1;
    seed_load = 1'b0;
    seed = 8'h00;
    enable = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    tick();
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_data", 64'(bus.out_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd1);
    chk("rst_count", 64'(count), 64'd0);

    sb.push_back(8'hB8);
    sb.push_back(8'h5C);
    sb.push_back(8'h2E);
    sb.push_back(8'h17);
    rst = 1'b0;
    tick();
    chk("warm_valid", 64'(bus.out_valid), 64'd0);
    chk("warm_busy", 64'(busy), 64'd0);
    tick();
    chk("first_valid", 64'(bus.out_valid), 64'd1);
    chk("first_data", 64'(bus.out_data), 64'hB8);
    repeat (4) tick();
    bus.out_ready = 1'b0;
    chk("base_fifth", 64'(bus.out_data), 64'hB3);
    chk("base_count", 64'(count), 64'd5);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk("stall_first", 64'(bus.out_data), 64'hB8);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_hold_data", 64'(bus.out_data), 64'hB8);
      chk("stall_hold_valid", 64'(bus.out_valid), 64'd1);
    end
    bus.out_ready = 1'b1;
    sb.push_back(8'hB8);
    sb.push_back(8'h5C);
    sb.push_back(8'h2E);
    repeat (3) tick();
    bus.out_ready = 1'b0;
    chk("stall_next", 64'(bus.out_data), 64'h17);
    chk("stall_count", 64'(count), 64'd4);

    seed = 8'h17;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    chk("reseed_valid", 64'(bus.out_valid), 64'd0);
    chk("reseed_busy", 64'(busy), 64'd1);
    chk("reseed_count", 64'(count), 64'd0);
    tick();
    chk("reseed_busy_end", 64'(busy), 64'd0);
    chk("reseed_valid_w", 64'(bus.out_valid), 64'd0);
    bus.out_ready = 1'b1;
    model_seed(8'h17);
    push_model(2);
    tick();
    chk("reseed_first", 64'(bus.out_data), 64'hB3);
    repeat (2) tick();
    bus.out_ready = 1'b0;

    seed = 8'h00;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    chk("zero_valid0", 64'(bus.out_valid), 64'd0);
    chk("zero_count", 64'(count), 64'd0);
    tick();
    chk("zero_valid1", 64'(bus.out_valid), 64'd0);
    bus.out_ready = 1'b1;
    model_seed(8'h00);
    push_model(4);
    tick();
    chk("zero_first", 64'(bus.out_data), 64'hB8);
    repeat (4) tick();
    bus.out_ready = 1'b0;
    chk("zero_fifth", 64'(bus.out_data), 64'hB3);
    chk("zero_count5", 64'(count), 64'd5);

    chk("pre_rst_valid", 64'(bus.out_valid), 64'd1);
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_data", 64'(bus.out_data), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd1);
    chk("mid_rst_count", 64'(count), 64'd0);

    enable = 1'b0;
    bus.out_ready = 1'b1;
    rst = 1'b0;
    repeat (4) tick();
    chk("gate_valid", 64'(bus.out_valid), 64'd0);
    chk("gate_count", 64'(count), 64'd0);
    hist.delete();
    model_seed(8'h01);
    push_model(256);
    enable = 1'b1;
    tick();
    chk("gate_first", 64'(bus.out_data), 64'hB8);
    for (int i = 1; i <= 256; i++) begin
      tick();
      if (i == 255) chk("period_count", 64'(count), 64'd256);
    end
    bus.out_ready = 1'b0;

    chk("period_words", 64'(hist.size()), 64'd256);
    bad = 0;
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    for (int i = 0; i < 255 && i < hist.size(); i++) begin
      if (hist[i] == 8'h00 || seen[hist[i]]) bad++;
      seen[hist[i]] = 1'b1;
    end
    chk("period_unique", 64'(bad), 64'd0);
    if (hist.size() == 256)
      chk("period_wrap", 64'(hist[255]), 64'(hist[0]));
    chk("sb_drain", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
